tick_gen_mc: RTL and testbench
==============================

// Module: tick_gen_mc
// PURPOSE
//  Multi-channel programmable tick generator; successor to the single fixed-period second-pulse block.
//  NCH independent channels, each with a runtime-programmable period, periodic/one-shot mode, and start/stop control.
//  Each channel emits a 1-cycle tick for display refresh, debounce and timeout logic.
//  Sits in the clk domain beside the counters/FSMs that consume its ticks.
// PARAMETERS
//  NCH        4        number of independent channels (1..16)
//  CNT_W      27       counter / period width in bits
//  DEF_PERIOD 7000000  reset value of every channel's period (must fit CNT_W)
// PORTS
//  clk        in   1               clock, all logic rising-edge
//  rst_n      in   1               asynchronous, active-low reset
//  start      in   NCH             per-channel start/restart strobe (1 cycle)
//  stop       in   NCH             per-channel stop strobe (1 cycle)
//  mode       in   NCH             per-channel mode: 0 = periodic, 1 = one-shot; sampled at start
//  cfg_we     in   1               period write strobe
//  cfg_ch     in   $clog2(NCH)     channel index for the period write
//  cfg_period in   CNT_W           new period value P; tick interval is P+1 clocks
//  tick       out  NCH             1-cycle tick pulse per channel (registered)
//  busy       out  NCH             channel in RUN state
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all channels IDLE; cnt=0; tick=0; busy=0.
//   - period and shadow registers = DEF_PERIOD; mode_q = 0.
//  Per-channel FSM, two states:
//   - IDLE -> RUN on start: cnt<=0, mode_q<=mode, busy<=1.
//   - RUN, cnt!=P: cnt<=cnt+1.
//   - RUN, cnt==P: cnt<=0, tick<=1 next cycle, P<=shadow.
//     If mode_q=1, go to IDLE and busy<=0 on the same edge tick rises.
//   - start while RUN: restart, cnt<=0, mode_q<=mode, no tick that cycle.
//   - stop (any state): IDLE, cnt<=0, no tick. stop+start in the same cycle: stop wins.
//  Tick timing:
//   - first tick is high in the cycle after edge S+P+1, where S is the edge that sampled start.
//   - periodic mode then repeats every P+1 clocks.
//   - P=0 in periodic mode: tick is high every cycle while RUN.
//   - tick is a pure register output and is never asserted in IDLE except the one-shot final pulse.
//  Period write (cfg_we=1):
//   - shadow[cfg_ch]<=cfg_period.
//   - channel IDLE: P also updates immediately.
//   - channel RUN: P updates only at the next wrap, so there is no short or long glitch period.
//   - cfg_ch>=NCH: write ignored.
//   - cfg_we coinciding with a wrap on the same channel: the new value is used from that wrap onward.
//  Counter: unsigned CNT_W bits; cnt never exceeds P because compare-reset uses ==.
//   - P is held stable within a period, so cnt cannot run past P.
//  Channels fully independent; simultaneous ticks on all channels are legal.
//  Reset asserted mid-run: immediate return to reset state; tick drops asynchronously.
// STRUCTURE
//  Shared package tick_pkg:
//   - chan_state_t {ST_IDLE, ST_RUN}
//   - mode_t {MD_PERIODIC, MD_ONESHOT}
//   - localparam CNT_W_DEF = 27
//  Sub-module tick_chan (one channel: FSM, cnt, P, shadow, tick register).
//  Top instantiates NCH copies via generate and decodes cfg_ch to a per-channel we.
// TESTING
//  1. Reset with start high -> tick=0, busy=0; after release and no start, tick stays 0 for 100 cycles.
//  2. cfg P=3 ch0, start ch0 periodic at edge 10 -> tick[0] high cycles 14, 18, 22; busy[0]=1 throughout.
//  3. ch1 one-shot P=5, start at edge 20 -> single tick cycle 26; busy[1] falls at edge 26; no further ticks.
//  4. ch0 running P=3, write P=7 at edge 15 -> next tick at 18, following ticks 26, 34 (update at wrap only).
//  5. start+stop same cycle on ch2 -> stays IDLE, no tick; stop mid-period on ch0 -> no tick, cnt=0, busy=0.
//  6. P=0 periodic on ch3 -> tick[3] high every cycle until stop; rst_n low mid-run clears all outputs immediately.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared types and defaults for the multi-channel tick generator.
package tick_pkg;

    localparam int unsigned CNT_W_DEF = 27;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } chan_state_t;

    typedef enum logic {
        MD_PERIODIC,
        MD_ONESHOT
    } mode_t;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: run/idle FSM, period counter, active and shadow period, tick register.
module tick_chan
    import tick_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned DEF_PERIOD = 7000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    output logic             tick_o,
    output logic             busy_o
);

    chan_state_t      state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic             tick_q, tick_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MD_PERIODIC;
            cnt_q   <= '0;
            per_q   <= CNT_W'(DEF_PERIOD);
            shd_q   <= CNT_W'(DEF_PERIOD);
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            shd_q   <= shd_d;
            tick_q  <= tick_d;
        end
    end

    // Stop beats start; start beats a wrap. A running period only adopts the shadow at its wrap.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        tick_d  = 1'b0;
        shd_d   = we_i ? cfg_period_i : shd_q;

        if (state_q == ST_IDLE && we_i) begin
            per_d = cfg_period_i;
        end

        if (stop_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            mode_d  = mode_i ? MD_ONESHOT : MD_PERIODIC;
        end else if (state_q == ST_RUN) begin
            if (cnt_q == per_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                per_d  = shd_d;
                if (mode_q == MD_ONESHOT) begin
                    state_d = ST_IDLE;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign tick_o = tick_q;
    assign busy_o = (state_q == ST_RUN);

endmodule

// File: rtl/tick_gen_mc.sv
// Multi-channel programmable tick generator: NCH independent tick_chan instances
// with a shared period-write port decoded per channel.
module tick_gen_mc
    import tick_pkg::*;
#(
    parameter  int unsigned NCH        = 4,
    parameter  int unsigned CNT_W      = CNT_W_DEF,
    parameter  int unsigned DEF_PERIOD = 7000000,
    localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   start,
    input  logic [NCH-1:0]   stop,
    input  logic [NCH-1:0]   mode,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   busy
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        // An out-of-range cfg_ch matches no channel, so the write is dropped.
        logic ch_we;
        assign ch_we = cfg_we && (cfg_ch == CH_W'(i));

        tick_chan #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .start_i      (start[i]),
            .stop_i       (stop[i]),
            .mode_i       (mode[i]),
            .we_i         (ch_we),
            .cfg_period_i (cfg_period),
            .tick_o       (tick[i]),
            .busy_o       (busy[i])
        );
    end

endmodule

// File: tb/tb_tick_gen_mc.sv
// Scoreboard bench for tick_gen_mc: a time-based reference model predicts tick/busy per edge.
module tb_tick_gen_mc;

    localparam int NCH        = 4;
    localparam int CNT_W      = 27;
    localparam int DEF_PERIOD = 7000000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   start, stop, mode;
    logic             cfg_we;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [NCH-1:0]   tick, busy;

    tick_gen_mc #(
        .NCH        (NCH),
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .tick       (tick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] t;
        logic [NCH-1:0] b;
    } exp_s;

    exp_s q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: each running channel knows the absolute edge of its next tick.
    longint m_per[NCH];
    longint m_shd[NCH];
    bit     m_run[NCH];
    bit     m_os[NCH];
    longint m_next[NCH];
    longint edge_n = 0;

    task automatic check(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_per[c]  = DEF_PERIOD;
            m_shd[c]  = DEF_PERIOD;
            m_run[c]  = 1'b0;
            m_os[c]   = 1'b0;
            m_next[c] = 0;
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected after the coming edge.
    task automatic step(input logic [NCH-1:0] st, input logic [NCH-1:0] sp, input logic [NCH-1:0] md,
                        input bit we, input int ch, input int unsigned per);
        exp_s e;
        @(negedge clk);
        start      = st;
        stop       = sp;
        mode       = md;
        cfg_we     = we;
        cfg_ch     = 2'(ch);
        cfg_period = CNT_W'(per);
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            bit was_run = m_run[c];
            bit wec     = we && (ch == c);
            if (wec) m_shd[c] = per;
            if (!was_run && wec) m_per[c] = per;
            if (sp[c]) begin
                m_run[c] = 1'b0;
            end else if (st[c]) begin
                m_run[c]  = 1'b1;
                m_os[c]   = md[c];
                m_next[c] = edge_n + m_per[c] + 1;
            end else if (was_run && edge_n == m_next[c]) begin
                e.t[c]   = 1'b1;
                m_per[c] = m_shd[c];
                if (m_os[c]) m_run[c] = 1'b0;
                else m_next[c] = edge_n + m_per[c] + 1;
            end
            e.b[c] = m_run[c];
        end
        q.push_back(e);
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, '0, 1'b0, 0, 0);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_tick", tick, '0);
        check("reset_busy", busy, '0);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_at_reset: got %0d pending expected 0", q.size());
            q.delete();
        end
        model_reset();
        @(negedge clk);
        start = '0; stop = '0; mode = '0; cfg_we = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: compare every edge for which a prediction exists.
    initial begin
        exp_s e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                check("tick", tick, e.t);
                check("busy", busy, e.b);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NCH-1:0] st, sp, md;
        rst_n      = 1'b0;
        start      = '1;
        stop       = '0;
        mode       = '0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        model_reset();
        #23;
        check("por_tick", tick, '0);
        check("por_busy", busy, '0);
        @(negedge clk);
        start = '0;
        rst_n = 1'b1;

        idle(100);

        // Periodic ch0 P=3, one-shot ch1 P=5, period rewrite on running ch0.
        step('0, '0, '0, 1'b1, 0, 3);
        step('0, '0, '0, 1'b1, 1, 5);
        step(4'b0001, '0, '0, 1'b0, 0, 0);
        idle(3);
        step(4'b0010, '0, 4'b0010, 1'b0, 0, 0);
        idle(2);
        step('0, '0, '0, 1'b1, 0, 7);
        idle(30);

        // start+stop together, then stop mid-period.
        step(4'b0100, 4'b0100, '0, 1'b0, 0, 0);
        idle(3);
        step('0, 4'b0001, '0, 1'b0, 0, 0);
        idle(5);

        // P=0 periodic on ch3: tick every cycle until stopped.
        step('0, '0, '0, 1'b1, 3, 0);
        step(4'b1000, '0, '0, 1'b0, 0, 0);
        idle(10);
        step('0, 4'b1000, '0, 1'b0, 0, 0);
        idle(3);

        // Randomised traffic with short periods.
        for (int c = 0; c < NCH; c++) step('0, '0, '0, 1'b1, c, $urandom_range(12, 0));
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                st[c] = ($urandom_range(39, 0) == 0);
                sp[c] = ($urandom_range(99, 0) == 0);
                md[c] = $urandom_range(1, 0) == 1;
            end
            step(st, sp, md, $urandom_range(9, 0) == 0, $urandom_range(NCH - 1, 0), $urandom_range(12, 0));
        end

        // Reset while ch3 ticks every cycle.
        step('0, '0, '0, 1'b1, 3, 0);
        step(4'b1000, '0, '0, 1'b0, 0, 0);
        idle(5);
        async_reset_check();

        // Recovery after reset.
        idle(5);
        step('0, '0, '0, 1'b1, 1, 2);
        step(4'b0010, '0, '0, 1'b0, 0, 0);
        idle(12);

        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
